// File: rtl/plic_pkg.sv
// Shared PLIC gateway types and default sizing.
package plic_pkg;

   localparam int PLIC_IRQ_NUM   = 32;
   localparam int PLIC_IRQ_WIDTH = $clog2(PLIC_IRQ_NUM);
   localparam int PLIC_GWP_WIDTH = 3;

   localparam logic LEVL = 1'b0;
   localparam logic EDGE = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      CLAIMED = 2'd2
   } gw_state_e;

endpackage

// File: rtl/plic_gateway_if.sv
// Control, source and claim/complete bundle between the PLIC core and the gateway array.
interface plic_gateway_if
   import plic_pkg::*;
#(
   parameter int IRQ_NUM   = PLIC_IRQ_NUM,
   parameter int IRQ_WIDTH = $clog2(IRQ_NUM),
   parameter int GWP_WIDTH = PLIC_GWP_WIDTH
);

   logic                 en_i;
   logic [GWP_WIDTH-1:0] tnm_i;
   logic [IRQ_NUM-1:0]   tm_i;
   logic [IRQ_NUM-1:0]   irq_i;
   logic                 claim_vld_i;
   logic [IRQ_WIDTH-1:0] claim_id_i;
   logic                 comp_vld_i;
   logic [IRQ_WIDTH-1:0] comp_id_i;
   logic [IRQ_NUM-1:0]   req_o;
   logic [IRQ_NUM-1:0]   inflight_o;

   modport master (
      output en_i, tnm_i, tm_i, irq_i, claim_vld_i, claim_id_i, comp_vld_i, comp_id_i,
      input  req_o, inflight_o
   );

   modport slave (
      input  en_i, tnm_i, tm_i, irq_i, claim_vld_i, claim_id_i, comp_vld_i, comp_id_i,
      output req_o, inflight_o
   );

endinterface

// File: rtl/plic_gateway_cell.sv
// One interrupt source: synchronizer, edge detect, pending-edge counter and gateway FSM.
module plic_gateway_cell
   import plic_pkg::*;
#(
   parameter int GWP_WIDTH   = PLIC_GWP_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [GWP_WIDTH-1:0] tnm_i,
   input  logic                 tm_i,
   input  logic                 irq_i,
   input  logic                 claim_i,
   input  logic                 comp_i,
   output logic                 req_o,
   output logic                 inflight_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;
   logic [GWP_WIDTH-1:0]   cnt_q, cnt_d, cnt_max;
   gw_state_e              state_q, state_d;
   logic                   sync_s, edge_s, avail, take;

   assign sync_s  = sync_q[SYNC_STAGES-1];
   assign edge_s  = sync_s & ~s_d_q;
   assign cnt_max = (tnm_i == '0) ? GWP_WIDTH'(1) : tnm_i;
   assign avail   = en_i && ((tm_i == EDGE) ? ((cnt_q != '0) || edge_s) : sync_s);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         s_d_q   <= 1'b0;
         cnt_q   <= '0;
         state_q <= IDLE;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_i};
         s_d_q   <= sync_s;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (avail) begin
               state_d = PEND;
               take    = 1'b1;
            end
         end
         PEND: begin
            if (claim_i) state_d = CLAIMED;
         end
         CLAIMED: begin
            if (comp_i) begin
               if (avail) begin
                  state_d = PEND;
                  take    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!en_i) state_d = IDLE;
   end

   // A consumed event comes from the counter when it holds any, otherwise from this cycle's edge.
   always_comb begin
      cnt_d = cnt_q;
      if (take && (cnt_q != '0)) cnt_d = cnt_q - GWP_WIDTH'(1);
      if (edge_s && !(take && (cnt_q == '0)) && (cnt_d < cnt_max)) cnt_d = cnt_d + GWP_WIDTH'(1);
      if (cnt_d > cnt_max) cnt_d = cnt_max;
      if (!en_i || (tm_i == LEVL)) cnt_d = '0;
   end

   assign req_o      = (state_q == PEND);
   assign inflight_o = (state_q == CLAIMED);

endmodule

// File: rtl/plic_gateway.sv
// Gateway array: one cell per source 1..IRQ_NUM-1, with claim/complete IDs decoded to one-hot strobes.
module plic_gateway
   import plic_pkg::*;
#(
   parameter int IRQ_NUM     = PLIC_IRQ_NUM,
   parameter int IRQ_WIDTH   = $clog2(IRQ_NUM),
   parameter int GWP_WIDTH   = PLIC_GWP_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   plic_gateway_if.slave gw
);

   logic [IRQ_NUM-1:1] claim_hit, comp_hit, req, inflight;
   logic               unused_src0;

   // Source 0 is reserved: no cell, so its inputs and ID 0 on the strobes fall away.
   assign unused_src0 = gw.irq_i[0] ^ gw.tm_i[0];

   always_comb begin
      claim_hit = '0;
      comp_hit  = '0;
      for (int unsigned k = 1; k < IRQ_NUM; k++) begin
         claim_hit[k] = gw.claim_vld_i && (gw.claim_id_i == IRQ_WIDTH'(k));
         comp_hit[k]  = gw.comp_vld_i && (gw.comp_id_i == IRQ_WIDTH'(k));
      end
   end

   for (genvar k = 1; k < IRQ_NUM; k++) begin : g_cell
      plic_gateway_cell #(
         .GWP_WIDTH  (GWP_WIDTH),
         .SYNC_STAGES(SYNC_STAGES)
      ) u_cell (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .en_i      (gw.en_i),
         .tnm_i     (gw.tnm_i),
         .tm_i      (gw.tm_i[k]),
         .irq_i     (gw.irq_i[k]),
         .claim_i   (claim_hit[k]),
         .comp_i    (comp_hit[k]),
         .req_o     (req[k]),
         .inflight_o(inflight[k])
      );
   end

   assign gw.req_o      = {req, 1'b0};
   assign gw.inflight_o = {inflight, 1'b0};

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed vector table, corner-case sequences and a randomized run against a reference model.
module tb_plic_gateway;

   localparam int IRQ_NUM   = 32;
   localparam int IRQ_WIDTH = 5;
   localparam int GWP_WIDTH = 3;
   localparam int SYNC      = 2;

   localparam logic [31:0] A  = 32'h0000_0220;
   localparam logic [31:0] B  = 32'h0000_0200;
   localparam logic [31:0] S5 = 32'h0000_0020;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en;
   logic [GWP_WIDTH-1:0] tnm;
   logic [IRQ_NUM-1:0]   tm, irq;
   logic                 claim_vld, comp_vld;
   logic [IRQ_WIDTH-1:0] claim_id, comp_id;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   plic_gateway_if #(.IRQ_NUM(IRQ_NUM), .IRQ_WIDTH(IRQ_WIDTH), .GWP_WIDTH(GWP_WIDTH)) gw_if ();

   assign gw_if.en_i        = en;
   assign gw_if.tnm_i       = tnm;
   assign gw_if.tm_i        = tm;
   assign gw_if.irq_i       = irq;
   assign gw_if.claim_vld_i = claim_vld;
   assign gw_if.claim_id_i  = claim_id;
   assign gw_if.comp_vld_i  = comp_vld;
   assign gw_if.comp_id_i   = comp_id;

   plic_gateway #(
      .IRQ_NUM    (IRQ_NUM),
      .IRQ_WIDTH  (IRQ_WIDTH),
      .GWP_WIDTH  (GWP_WIDTH),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .gw   (gw_if)
   );

   // Reference model: request/in-flight flags, a count of stored events, and the raw
   // input history from which the synchronized level and its edges are derived.
   logic [IRQ_NUM-1:0] m_req, m_infl;
   int                 m_cnt [IRQ_NUM];
   logic [IRQ_NUM-1:0] smp [SYNC+1];

   task automatic model_reset();
      m_req  = '0;
      m_infl = '0;
      for (int k = 0; k < IRQ_NUM; k++) m_cnt[k] = 0;
      for (int i = 0; i <= SYNC; i++) smp[i] = '0;
   endtask

   task automatic model_edge();
      logic [IRQ_NUM-1:0] s, sd, nreq, ninfl;
      int mx;
      s     = smp[SYNC-1];
      sd    = smp[SYNC];
      mx    = (tnm == 0) ? 1 : int'(tnm);
      nreq  = m_req;
      ninfl = m_infl;
      for (int k = 1; k < IRQ_NUM; k++) begin
         bit e, avail, took;
         int v;
         e     = s[k] && !sd[k];
         avail = tm[k] ? ((m_cnt[k] > 0) || e) : s[k];
         took  = 1'b0;
         if (!en) begin
            nreq[k]  = 1'b0;
            ninfl[k] = 1'b0;
            m_cnt[k] = 0;
         end else begin
            if (m_req[k] && claim_vld && (int'(claim_id) == k)) begin
               nreq[k]  = 1'b0;
               ninfl[k] = 1'b1;
            end else if (m_infl[k] && comp_vld && (int'(comp_id) == k)) begin
               ninfl[k] = 1'b0;
               if (avail) begin
                  nreq[k] = 1'b1;
                  took    = 1'b1;
               end
            end else if (!m_req[k] && !m_infl[k] && avail) begin
               nreq[k] = 1'b1;
               took    = 1'b1;
            end
            if (!tm[k]) begin
               m_cnt[k] = 0;
            end else begin
               v        = m_cnt[k] + int'(e) - int'(took);
               m_cnt[k] = (v > mx) ? mx : v;
            end
         end
      end
      m_req  = nreq;
      m_infl = ninfl;
      for (int i = SYNC; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = irq;
   endtask

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cmp("model_req", gw_if.req_o, m_req);
      cmp("model_infl", gw_if.inflight_o, m_infl);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en = 1'b0; tnm = '0; tm = '0; irq = '0;
      claim_vld = 1'b0; claim_id = '0; comp_vld = 1'b0; comp_id = '0;
      #1;
      cmp("rst_req", gw_if.req_o, 32'h0);
      cmp("rst_infl", gw_if.inflight_o, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse(input int k);
      irq[k] = 1'b1;
      step();
      irq[k] = 1'b0;
      step();
   endtask

   task automatic claim(input int k);
      claim_vld = 1'b1;
      claim_id  = IRQ_WIDTH'(k);
      step();
      claim_vld = 1'b0;
   endtask

   task automatic comp(input int k);
      comp_vld = 1'b1;
      comp_id  = IRQ_WIDTH'(k);
      step();
      comp_vld = 1'b0;
   endtask

   function automatic logic [IRQ_WIDTH-1:0] pick_id(input logic [IRQ_NUM-1:0] v);
      int q[$];
      for (int k = 0; k < IRQ_NUM; k++) if (v[k]) q.push_back(k);
      if ((q.size() == 0) || ($urandom_range(3, 0) == 0)) return IRQ_WIDTH'($urandom_range(IRQ_NUM-1, 0));
      return IRQ_WIDTH'(q[$urandom_range(q.size()-1, 0)]);
   endfunction

   typedef struct {
      logic [31:0]          irq;
      logic                 claim_vld;
      logic [IRQ_WIDTH-1:0] claim_id;
      logic                 comp_vld;
      logic [IRQ_WIDTH-1:0] comp_id;
      logic [31:0]          exp_req;
      logic [31:0]          exp_infl;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // Level mode on sources 5 and 9; each row is held for one clock, expectations are post-edge.
      tbl[0]  = '{A, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0};
      tbl[1]  = '{A, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0};
      tbl[2]  = '{A, 1'b0, 5'd0, 1'b0, 5'd0, A,     32'h0};
      tbl[3]  = '{A, 1'b1, 5'd5, 1'b0, 5'd0, B,     S5};
      tbl[4]  = '{A, 1'b0, 5'd0, 1'b0, 5'd0, B,     S5};
      tbl[5]  = '{A, 1'b0, 5'd0, 1'b1, 5'd5, A,     32'h0};
      tbl[6]  = '{A, 1'b0, 5'd0, 1'b1, 5'd9, A,     32'h0};
      tbl[7]  = '{B, 1'b1, 5'd0, 1'b1, 5'd0, A,     32'h0};
      tbl[8]  = '{B, 1'b1, 5'd5, 1'b0, 5'd0, B,     S5};
      tbl[9]  = '{B, 1'b0, 5'd0, 1'b1, 5'd5, B,     32'h0};
      tbl[10] = '{B, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, B};
      tbl[11] = '{B, 1'b0, 5'd0, 1'b1, 5'd9, B,     32'h0};

      model_reset();
      do_reset();
      en = 1'b1; tnm = 3'd3; tm = '0;
      for (int i = 0; i < 12; i++) begin
         irq       = tbl[i].irq;
         claim_vld = tbl[i].claim_vld;
         claim_id  = tbl[i].claim_id;
         comp_vld  = tbl[i].comp_vld;
         comp_id   = tbl[i].comp_id;
         step();
         cmp($sformatf("tbl%0d_req", i), gw_if.req_o, tbl[i].exp_req);
         cmp($sformatf("tbl%0d_infl", i), gw_if.inflight_o, tbl[i].exp_infl);
      end
      claim_vld = 1'b0;
      comp_vld  = 1'b0;

      // Edge counting with saturation at 3: five pulses give one request plus three stored.
      do_reset();
      en = 1'b1; tnm = 3'd3; tm = 32'h8;
      irq[3] = 1'b1; step();
      irq[3] = 1'b0; step();
      step();
      cmp("edge_first_req3", 32'(gw_if.req_o[3]), 32'd1);
      for (int p = 0; p < 4; p++) pulse(3);
      step(); step();
      for (int r = 0; r < 3; r++) begin
         claim(3);
         cmp($sformatf("edge_claim%0d_infl3", r), 32'(gw_if.inflight_o[3]), 32'd1);
         comp(3);
         cmp($sformatf("edge_repend%0d_req3", r), 32'(gw_if.req_o[3]), 32'd1);
      end
      claim(3);
      comp(3);
      cmp("edge_drain_req3", 32'(gw_if.req_o[3]), 32'd0);
      cmp("edge_drain_infl3", 32'(gw_if.inflight_o[3]), 32'd0);

      // tnm = 0 behaves as a maximum of one stored edge.
      do_reset();
      en = 1'b1; tnm = 3'd0; tm = 32'h80;
      pulse(7); pulse(7);
      step(); step();
      cmp("tnm0_req7", 32'(gw_if.req_o[7]), 32'd1);
      claim(7); comp(7);
      cmp("tnm0_repend_req7", 32'(gw_if.req_o[7]), 32'd1);
      claim(7); comp(7);
      cmp("tnm0_idle_req7", 32'(gw_if.req_o[7]), 32'd0);

      // Edge arriving while claimed re-pends on completion; the counter is empty afterwards.
      do_reset();
      en = 1'b1; tnm = 3'd3; tm = 32'h10;
      pulse(4); step(); step();
      cmp("eclaim_pend_req4", 32'(gw_if.req_o[4]), 32'd1);
      claim(4);
      pulse(4); step(); step();
      cmp("eclaim_infl4", 32'(gw_if.inflight_o[4]), 32'd1);
      comp(4);
      cmp("eclaim_repend_req4", 32'(gw_if.req_o[4]), 32'd1);
      claim(4); comp(4);
      cmp("eclaim_idle_req4", 32'(gw_if.req_o[4]), 32'd0);

      // Global disable with one source pending and one claimed holding two stored edges.
      do_reset();
      en = 1'b1; tnm = 3'd3; tm = 32'h40;
      irq[2] = 1'b1;
      pulse(6); step(); step();
      claim(6);
      pulse(6); pulse(6); step();
      cmp("endrop_pre_req", gw_if.req_o, 32'h4);
      cmp("endrop_pre_infl", gw_if.inflight_o, 32'h40);
      en = 1'b0; irq = '0;
      step();
      cmp("endrop_req", gw_if.req_o, 32'h0);
      cmp("endrop_infl", gw_if.inflight_o, 32'h0);
      step(); step(); step();
      en = 1'b1;
      for (int i = 0; i < 4; i++) step();
      cmp("reen_req", gw_if.req_o, 32'h0);
      cmp("reen_infl", gw_if.inflight_o, 32'h0);

      // Randomized traffic against the model, including an asynchronous reset mid-run.
      do_reset();
      en = 1'b1; tnm = GWP_WIDTH'($urandom_range(7, 0)); tm = $urandom;
      for (int i = 0; i < 3000; i++) begin
         logic [IRQ_NUM-1:0] flip;
         if (i == 1500) begin
            irq[1] = 1'b1;
            step();
            #2;
            rst = 1'b1;
            #1;
            cmp("async_rst_req", gw_if.req_o, 32'h0);
            cmp("async_rst_infl", gw_if.inflight_o, 32'h0);
            do_reset();
            en = 1'b1; tnm = GWP_WIDTH'($urandom_range(7, 0)); tm = $urandom;
         end
         flip = '0;
         for (int k = 0; k < IRQ_NUM; k++) flip[k] = ($urandom_range(5, 0) == 0);
         irq = irq ^ flip;
         if ($urandom_range(199, 0) == 0) begin
            int b;
            b = int'($urandom_range(IRQ_NUM-1, 0));
            tm[b] = ~tm[b];
         end
         if ($urandom_range(99, 0) == 0) tnm = GWP_WIDTH'($urandom_range(7, 0));
         en        = ($urandom_range(99, 0) != 0);
         claim_vld = ($urandom_range(1, 0) == 1);
         claim_id  = pick_id(m_req);
         comp_vld  = ($urandom_range(1, 0) == 1);
         comp_id   = pick_id(m_infl);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
